test_status_ctrl: RTL and testbench

//   Memory-mapped test-status peripheral inside main. Firmware writes a pass/fail

---
 rtl/test_status_ctrl.sv | 157 +++++++++++++++
 tb/tb_test_status_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/test_status_ctrl.sv
// Test-status peripheral: firmware pass/fail word, hardware watchdog, cycle counter, status LEDs.
// Latency: writes change state and LEDs on the next edge; reads return data one cycle after rd_en.
// Backpressure: none; the slave accepts one write and one read every cycle.
module test_status_ctrl #(
   parameter logic [31:0] WDT_CYCLES = 32'h8000,
   parameter int          HB_LOG2    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rd_en,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        user_led0,
   output logic        user_led1,
   output logic        user_led2,
   output logic        user_led3
);

   // Two-bit encoding is visible to firmware through STATUS[1:0].
   typedef enum logic [1:0] {
      RUN     = 2'b00,
      PASS    = 2'b01,
      FAIL    = 2'b10,
      TIMEOUT = 2'b11
   } state_t;

   // Word index of each register (byte offset bits [3:2]).
   localparam logic [1:0] A_TOHOST = 2'd0;
   localparam logic [1:0] A_KICK   = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_CYCLES = 2'd3;

   state_t              state;
   logic [23:0]         code;
   logic [31:0]         cycles;
   logic [31:0]         wdt;
   logic [HB_LOG2-1:0]  hb_cnt;

   logic tohost_wr;
   logic kick_wr;
   logic reload;
   logic pass_req;
   logic fail_req;
   logic wdt_on;
   logic expire;
   logic in_run;

   // Byte-lane bits of the offsets carry no meaning for word registers.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

   // Decode bus writes and watchdog expiry for the current cycle.
   always_comb begin
      in_run    = (state == RUN);
      tohost_wr = wr_en && (wr_addr[3:2] == A_TOHOST);
      kick_wr   = wr_en && (wr_addr[3:2] == A_KICK);
      reload    = tohost_wr || kick_wr;
      pass_req  = tohost_wr && (wr_data == 32'd1);
      fail_req  = tohost_wr && wr_data[0] && (wr_data != 32'd1);
      wdt_on    = (WDT_CYCLES != 32'd0);
      // A reload in the expiry cycle pushes the deadline out, so no timeout.
      expire    = wdt_on && !reload && (wdt == 32'd1);
   end

   // Test-status FSM with registered LEDs; PASS/FAIL writes take priority over expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         code      <= 24'd0;
         user_led0 <= 1'b0;
         user_led1 <= 1'b0;
         user_led2 <= 1'b0;
         user_led3 <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (pass_req) begin
                  state     <= PASS;
                  user_led0 <= 1'b0;
                  user_led3 <= 1'b1;
               end else if (fail_req) begin
                  state     <= FAIL;
                  code      <= wr_data[24:1];
                  user_led0 <= 1'b0;
                  user_led1 <= 1'b1;
                  user_led3 <= 1'b1;
               end else if (expire) begin
                  state     <= TIMEOUT;
                  user_led0 <= 1'b0;
                  user_led1 <= 1'b1;
                  user_led2 <= 1'b1;
                  user_led3 <= 1'b1;
               end else if (&hb_cnt) begin
                  user_led0 <= ~user_led0;
               end
            end
            // Terminal states are sticky until reset; bus writes are ignored.
            default: begin
               state <= state;
            end
         endcase
      end
   end

   // Heartbeat prescaler: wraps every 2**HB_LOG2 cycles while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt <= '0;
      end else if (in_run) begin
         hb_cnt <= hb_cnt + 1'b1;
      end
   end

   // Watchdog down-counter; any KICK or TOHOST write reloads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt <= WDT_CYCLES;
      end else if (in_run && wdt_on) begin
         if (reload) begin
            wdt <= WDT_CYCLES;
         end else if (wdt != 32'd0) begin
            wdt <= wdt - 32'd1;
         end
      end
   end

   // Cycle counter: counts while running, saturates, freezes on leaving RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles <= 32'd0;
      end else if (in_run && (cycles != 32'hFFFF_FFFF)) begin
         cycles <= cycles + 32'd1;
      end
   end

   // Read port: samples pre-write register values; rd_data holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= 32'd0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            case (rd_addr[3:2])
               A_STATUS: rd_data <= {code, 6'b0, state};
               A_CYCLES: rd_data <= cycles;
               default:  rd_data <= 32'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_test_status_ctrl.sv
// Directed bench for test_status_ctrl with a short watchdog and fast heartbeat.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Each step issues at most one write and one read, so no backpressure handling.
module tb_test_status_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = 4'h0;
   logic [31:0] wr_data = 32'h0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = 4'h0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        user_led0;
   logic        user_led1;
   logic        user_led2;
   logic        user_led3;

   int nvec = 0;
   int nerr = 0;

   test_status_ctrl #(
      .WDT_CYCLES (32'd16),
      .HB_LOG2    (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .user_led0 (user_led0),
      .user_led1 (user_led1),
      .user_led2 (user_led2),
      .user_led3 (user_led3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] leds();
      return {28'd0, user_led3, user_led2, user_led1, user_led0};
   endfunction

   // Hold reset for two edges, check reset outputs, release mid-cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      step(2);
      chk("rst_leds", leds(), 32'h0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'h0);
      chk("rst_rd_data", rd_data, 32'h0);
      #2 rst_n = 1'b1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step(1);
      wr_en   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      step(1);
      rd_en   = 1'b0;
      chk({tag, "_vld"}, {31'd0, rd_valid}, 32'h1);
      chk(tag, rd_data, exp);
   endtask

   initial begin
      // 1: kick at edge 10, TOHOST=1 at edge 20 -> PASS, cycles frozen at 20
      do_reset();
      step(9);
      wr(4'h4, 32'hDEAD_BEEF);
      step(9);
      wr(4'h0, 32'd1);
      chk("t1_leds_pass", leds(), 32'h8);
      rd("t1_status", 4'h8, 32'h0000_0001);
      rd("t1_cycles_a", 4'hC, 32'd20);
      rd("t1_cycles_b", 4'hC, 32'd20);
      step(1);
      chk("t1_rd_valid_idle", {31'd0, rd_valid}, 32'h0);
      chk("t1_rd_data_hold", rd_data, 32'd20);

      // 2: TOHOST=7 -> FAIL with code 3; later PASS write ignored
      do_reset();
      wr(4'h0, 32'd7);
      chk("t2_leds_fail", leds(), 32'hA);
      rd("t2_status", 4'h8, 32'h0000_0302);
      wr(4'h0, 32'd1);
      rd("t2_status_sticky", 4'h8, 32'h0000_0302);
      rd("t2_cycles", 4'hC, 32'd1);
      rd("t2_tohost_rd", 4'h0, 32'd0);

      // 3: no writes -> TIMEOUT exactly 16 edges after release
      do_reset();
      step(15);
      chk("t3_before_expiry", leds() & 32'hE, 32'h0);
      step(1);
      chk("t3_leds_timeout", leds(), 32'hE);
      rd("t3_status", 4'h8, 32'h0000_0003);

      // 4: kick every 10 cycles for 200 cycles -> no timeout
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(9);
         wr(4'h4, 32'd0);
         chk("t4_no_timeout", {31'd0, user_led3}, 32'h0);
      end
      // PASS write on the expiry cycle, with a same-cycle STATUS read (pre-write value)
      step(15);
      wr_en   = 1'b1;
      wr_addr = 4'h0;
      wr_data = 32'd1;
      rd_en   = 1'b1;
      rd_addr = 4'h8;
      step(1);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      chk("t4_leds_pass", leds(), 32'h8);
      chk("t4_status_prewrite", rd_data, 32'h0);
      rd("t4_status_pass", 4'h8, 32'h0000_0001);
      rd("t4_cycles", 4'hC, 32'd216);

      // 5: heartbeat toggles every 4 cycles; even TOHOST reloads watchdog
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1);
         chk("t5_heartbeat", {31'd0, user_led0}, ((i / 4) % 2 == 1) ? 32'h1 : 32'h0);
      end
      step(6);
      wr(4'h0, 32'd4);
      step(15);
      chk("t5_even_reload", leds(), 32'h1);
      wr(4'h0, 32'd1);
      chk("t5_leds_pass", leds(), 32'h8);

      // 6: reset asserted in FAIL with a read pending
      do_reset();
      wr(4'h0, 32'd7);
      rd_en   = 1'b1;
      rd_addr = 4'hC;
      step(1);
      chk("t6_rd_before_rst", rd_data, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_leds", leds(), 32'h0);
      chk("t6_async_rd_valid", {31'd0, rd_valid}, 32'h0);
      chk("t6_async_rd_data", rd_data, 32'h0);
      rd_en = 1'b0;
      #1 rst_n = 1'b1;
      step(3);
      rd("t6_cycles_restart", 4'hC, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
